cache_memory_call_direct_map: RTL and testbench

CACHE_MEMORY_CALL_DIRECT_MAP -- requirements
Module: cache_memory_call_direct_map

---
 rtl/cache_memory_call_direct_map.sv | 111 +++++++++++
 tb/tb_cache_memory_call_direct_map.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_memory_call_direct_map.sv
// Direct-mapped, read-only cache in front of a computed block ROM.
// Requests are handled one at a time by a five-state controller.
module cache_memory_call_direct_map #(
  parameter int ADDR_W    = 15,
  parameter int LINE_W    = 128,
  parameter int NUM_LINES = 32
) (
  input  logic              globalclock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  output logic              done,
  output logic [31:0]       outData_cache,
  output logic [LINE_W-1:0] memOut
);

  localparam int WORDS = LINE_W / 32;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int BLK_W = ADDR_W - 4;
  localparam int TAG_W = BLK_W - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_READ,
    FILL,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] req_q;
  logic              done_q;
  logic [31:0]       out_q;
  logic [LINE_W-1:0] mem_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [LINE_W-1:0] line_q [NUM_LINES];

  logic [1:0]        req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [BLK_W-1:0]  req_blk;
  logic [LINE_W-1:0] rom_block;
  logic [31:0]       line_word;
  logic              hit;
  logic              unused_byte_off;

  assign req_word        = req_q[3:2];
  assign req_idx         = req_q[4 +: IDX_W];
  assign req_tag         = req_q[ADDR_W-1 -: TAG_W];
  assign req_blk         = req_q[ADDR_W-1:4];
  assign unused_byte_off = ^req_q[1:0];

  // Main memory is a pure function of the block number: word w holds {block, w}.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_rom_word
      assign rom_block[gi*32 +: 32] = {{(32-BLK_W-2){1'b0}}, req_blk, 2'(gi)};
    end
  endgenerate

  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign line_word = line_q[req_idx][32*req_word +: 32];

  always_ff @(posedge globalclock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = LOOKUP;
      LOOKUP:   state_d = hit ? DONE : MEM_READ;
      MEM_READ: state_d = FILL;
      FILL:     state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // done and the returned word are registered on the edge that leaves DONE.
  always_ff @(posedge globalclock) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
      mem_q   <= '0;
      req_q   <= '0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == IDLE && start) req_q <= address;
      if (state_q == MEM_READ)      mem_q <= rom_block;
      if (state_q == FILL)          valid_q[req_idx] <= 1'b1;
      if (state_q == DONE)          out_q <= line_word;
    end
  end

  // Line data and tags need no reset; the valid bits gate them.
  always_ff @(posedge globalclock) begin
    if (state_q == FILL && !reset) begin
      line_q[req_idx] <= mem_q;
      tag_q[req_idx]  <= req_tag;
    end
  end

  assign done          = done_q;
  assign outData_cache = out_q;
  assign memOut        = mem_q;

endmodule

// File: tb/tb_cache_memory_call_direct_map.sv
// Randomised scoreboard bench for the direct-mapped cache; the model tracks
// which block each line holds and derives data, memOut and latency from it.
module tb_cache_memory_call_direct_map;

  logic         globalclock = 1'b0;
  logic         reset;
  logic         start;
  logic [14:0]  address;
  logic         done;
  logic [31:0]  outData_cache;
  logic [127:0] memOut;

  cache_memory_call_direct_map dut (
    .globalclock   (globalclock),
    .reset         (reset),
    .start         (start),
    .address       (address),
    .done          (done),
    .outData_cache (outData_cache),
    .memOut        (memOut)
  );

  always #5 globalclock = ~globalclock;

  typedef struct {
    int unsigned accept;
    int unsigned lat;
    logic [31:0] data;
    logic [127:0] mem;
    logic [14:0] addr;
  } exp_t;

  exp_t         sb[$];
  int           model_blk[32];
  logic [127:0] model_mem;
  int unsigned  cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic         done_prev = 1'b0;
  exp_t         mon_e;

  always @(posedge globalclock) cyc++;

  function automatic logic [127:0] block_value(int unsigned blk);
    logic [127:0] v;
    for (int w = 0; w < 4; w++) v[w*32 +: 32] = 32'(blk * 4 + w);
    return v;
  endfunction

  function automatic logic [14:0] rand_addr();
    logic [14:0] a;
    if ($urandom_range(0, 9) == 0) a = 15'($urandom);
    else a = {6'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 4'($urandom)};
    return a;
  endfunction

  task automatic predict(input logic [14:0] a, input int unsigned acc, output int unsigned lat);
    exp_t e;
    int unsigned blk = 32'(a[14:4]);
    int idx = int'(blk % 32);
    bit is_hit = (model_blk[idx] == int'(blk));
    if (!is_hit) begin
      model_blk[idx] = int'(blk);
      model_mem = block_value(blk);
    end
    e.accept = acc;
    e.lat    = is_hit ? 2 : 4;
    e.data   = 32'(blk * 4 + 32'(a[3:2]));
    e.mem    = model_mem;
    e.addr   = a;
    lat      = e.lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge globalclock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic req(input logic [14:0] a);
    int unsigned lat;
    @(negedge globalclock);
    start = 1'b1;
    address = a;
    predict(a, cyc + 1, lat);
    @(negedge globalclock);
    start = 1'b0;
    address = 15'($urandom);
    wait_drain("req");
  endtask

  // start stays high; the address changes every cycle and only the value
  // present at each predicted acceptance edge may be taken.
  task automatic held_run(input int n);
    int unsigned next;
    int unsigned lat;
    int issued = 0;
    @(negedge globalclock);
    start = 1'b1;
    next = cyc + 1;
    while (issued < n) begin
      address = rand_addr();
      if (cyc + 1 == next) begin
        predict(address, next, lat);
        next = next + lat + 1;
        issued++;
      end
      @(negedge globalclock);
    end
    start = 1'b0;
    address = 15'($urandom);
    wait_drain("held");
  endtask

  task automatic check_zero_outputs(input string name);
    checks += 3;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got=%b required=0", name, done);
    end
    if (outData_cache !== 32'h0) begin
      errors++;
      $display("FAIL %s_outData got=%h required=0", name, outData_cache);
    end
    if (memOut !== 128'h0) begin
      errors++;
      $display("FAIL %s_memOut got=%h required=0", name, memOut);
    end
  endtask

  // Reset lands on the edge where the DUT sits in MEM_READ of a miss.
  task automatic reset_mid(input logic [14:0] a);
    @(negedge globalclock);
    start = 1'b1;
    address = a;
    @(negedge globalclock);
    start = 1'b0;
    @(negedge globalclock);
    reset = 1'b1;
    @(negedge globalclock);
    reset = 1'b0;
    check_zero_outputs("midreset");
    for (int i = 0; i < 32; i++) model_blk[i] = -1;
    model_mem = '0;
    repeat (4) begin
      @(negedge globalclock);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL midreset_idle_done got=%b required=0", done);
      end
    end
  endtask

  always @(negedge globalclock) begin
    if (done === 1'b1) begin
      checks++;
      if (done_prev) begin
        errors++;
        $display("FAIL done_consecutive got=1 required=0 at edge %0d", cyc);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at edge %0d outData=%h", cyc, outData_cache);
      end else begin
        mon_e = sb.pop_front();
        checks += 3;
        $display("txn addr=%h data=%h memOut=%h edge=%0d", mon_e.addr, outData_cache, memOut, cyc);
        if (cyc != mon_e.accept + mon_e.lat) begin
          errors++;
          $display("FAIL latency addr=%h got=%0d required=%0d", mon_e.addr,
                   cyc - mon_e.accept, mon_e.lat);
        end
        if (outData_cache !== mon_e.data) begin
          errors++;
          $display("FAIL outData addr=%h got=%h required=%h", mon_e.addr, outData_cache, mon_e.data);
        end
        if (memOut !== mon_e.mem) begin
          errors++;
          $display("FAIL memOut addr=%h got=%h required=%h", mon_e.addr, memOut, mon_e.mem);
        end
      end
    end
    done_prev = done;
  end

  initial begin
    for (int i = 0; i < 32; i++) model_blk[i] = -1;
    model_mem = '0;
    reset   = 1'b1;
    start   = 1'b1;
    address = 15'h7833;
    repeat (3) @(negedge globalclock);
    check_zero_outputs("reset");
    start = 1'b0;
    reset = 1'b0;

    req(15'h7833);
    checks++;
    if (memOut !== 128'h00001E0F_00001E0E_00001E0D_00001E0C) begin
      errors++;
      $display("FAIL first_block got=%h required=00001e0f00001e0e00001e0d00001e0c", memOut);
    end
    req(15'h783B);
    req(15'h7A33);
    req(15'h7833);
    reset_mid(15'h7A33);
    req(15'h7833);
    req(15'h7837);

    held_run(30);
    for (int i = 0; i < 60; i++) req(rand_addr());
    held_run(30);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
